// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache and its memory-controller interface.
// The IF data width macro is shared with the memory controller so both agree on burst size.
`ifndef ICACHE_IF_DATA_W
`define ICACHE_IF_DATA_W 512
`endif

package icache_pkg;

  localparam int ICACHE_LINE_BYTES = 64;
  localparam int ICACHE_LINE_W     = `ICACHE_IF_DATA_W;
  localparam int ICACHE_WORD_W     = 32;
  localparam int ICACHE_ADDR_W     = 32;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache with combinational hit path and a single
// outstanding line fill to the memory controller.
module icache
  import icache_pkg::*;
#(
  parameter int LINE_NUM   = 16,
  parameter int LINE_BYTES = ICACHE_LINE_BYTES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic                     fetch_en,
  input  logic [ICACHE_ADDR_W-1:0] fetch_pc,
  output logic                     fetch_hit,
  output logic [ICACHE_WORD_W-1:0] fetch_inst,
  output logic                     mem_if_en,
  output logic [ICACHE_ADDR_W-1:0] mem_if_pc,
  input  logic [ICACHE_LINE_W-1:0] mem_if_data,
  input  logic                     mem_if_done
);

  localparam int IW     = $clog2(LINE_NUM);
  localparam int OW     = $clog2(LINE_BYTES);
  localparam int TW     = ICACHE_ADDR_W - OW - IW;
  localparam int WSEL_W = OW - 2;

  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag;
  logic [WSEL_W-1:0] wsel;

  assign idx  = fetch_pc[OW+IW-1:OW];
  assign tag  = fetch_pc[ICACHE_ADDR_W-1:OW+IW];
  assign wsel = fetch_pc[OW-1:2];

  logic [ICACHE_LINE_W-1:0] line_q [LINE_NUM];
  logic [TW-1:0]            tag_q  [LINE_NUM];
  logic [LINE_NUM-1:0]      valid_q;

  icache_state_e            state_q;
  logic                     mem_if_en_q;
  logic [ICACHE_ADDR_W-1:0] mem_if_pc_q;

  // Fill destination is recovered from the latched fill address, so a
  // moving fetch_pc during WAIT_MEM cannot redirect the install.
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;

  assign fill_idx = mem_if_pc_q[OW+IW-1:OW];
  assign fill_tag = mem_if_pc_q[ICACHE_ADDR_W-1:OW+IW];

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], mem_if_pc_q[OW-1:0]};

  logic lookup_hit;
  logic fill_start;
  logic fill_done;

  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
  assign fetch_hit  = fetch_en && lookup_hit && (state_q == ST_IDLE);
  assign fetch_inst = line_q[idx][{wsel, 5'b0} +: ICACHE_WORD_W];

  assign fill_start = rdy && (state_q == ST_IDLE) && fetch_en && !lookup_hit && !rollback;
  assign fill_done  = rdy && (state_q == ST_WAIT_MEM) && mem_if_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_if_en_q <= 1'b0;
      mem_if_pc_q <= '0;
      valid_q     <= '0;
    end else if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (fill_start) begin
            mem_if_en_q <= 1'b1;
            mem_if_pc_q <= {fetch_pc[ICACHE_ADDR_W-1:OW], {OW{1'b0}}};
            state_q     <= ST_WAIT_MEM;
          end
        end
        ST_WAIT_MEM: begin
          // Rollback is deliberately ignored here: the burst cannot be cancelled.
          if (mem_if_done) begin
            valid_q[fill_idx] <= 1'b1;
            mem_if_en_q       <= 1'b0;
            state_q           <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_if_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      line_q[fill_idx] <= mem_if_data;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  assign mem_if_en = mem_if_en_q;
  assign mem_if_pc = mem_if_pc_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, rollback, stall and async reset.
module tb_icache;
  import icache_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         rdy;
  logic         rollback;
  logic         fetch_en;
  logic [31:0]  fetch_pc;
  logic         fetch_hit;
  logic [31:0]  fetch_inst;
  logic         mem_if_en;
  logic [31:0]  mem_if_pc;
  logic [511:0] mem_if_data;
  logic         mem_if_done;

  int n_cmp;
  int n_bad;

  icache #(.LINE_NUM(16), .LINE_BYTES(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .rollback   (rollback),
    .fetch_en   (fetch_en),
    .fetch_pc   (fetch_pc),
    .fetch_hit  (fetch_hit),
    .fetch_inst (fetch_inst),
    .mem_if_en  (mem_if_en),
    .mem_if_pc  (mem_if_pc),
    .mem_if_data(mem_if_data),
    .mem_if_done(mem_if_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Byte i of a line = base[7:0] + i + 16*base[11:8]; gives distinct, hand-checkable words.
  function automatic logic [511:0] build_line(input logic [31:0] base);
    logic [511:0] l;
    logic [7:0]   b;
    l = '0;
    for (int i = 0; i < 64; i++) begin
      b = base[7:0] + 8'(i) + {base[11:8], 4'b0};
      l[8*i +: 8] = b;
    end
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Pulse done for one cycle with the given line's data, then return to idle inputs.
  task automatic give_fill(input logic [31:0] base);
    mem_if_data = build_line(base);
    mem_if_done = 1'b1;
    settle();
    check("hit_low_in_done_cycle", {31'b0, fetch_hit}, 32'h0);
    tick();
    mem_if_done = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    rdy = 1'b1;
    rollback = 1'b0;
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_1044;
    mem_if_data = '0;
    mem_if_done = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_mem_if_en", {31'b0, mem_if_en}, 32'h0);
    check("rst_mem_if_pc", mem_if_pc, 32'h0);
    check("rst_fetch_hit", {31'b0, fetch_hit}, 32'h0);
    rst_n = 1'b1;
    settle();

    // Cold miss at 0x1044
    check("cold_miss_hit", {31'b0, fetch_hit}, 32'h0);
    tick();
    check("cold_req_en", {31'b0, mem_if_en}, 32'h1);
    check("cold_req_pc", mem_if_pc, 32'h0000_1040);
    fetch_pc = 32'h0000_2000;
    tick();
    tick();
    check("pc_change_ignored", mem_if_pc, 32'h0000_1040);
    check("en_held", {31'b0, mem_if_en}, 32'h1);
    fetch_pc = 32'h0000_1044;
    give_fill(32'h0000_1040);
    check("en_low_after_done", {31'b0, mem_if_en}, 32'h0);
    check("cold_fill_hit", {31'b0, fetch_hit}, 32'h1);
    check("cold_fill_inst", fetch_inst, 32'h4746_4544);

    // Hit on same line, no request
    fetch_pc = 32'h0000_107C;
    settle();
    check("same_line_hit", {31'b0, fetch_hit}, 32'h1);
    check("same_line_inst", fetch_inst, 32'h7F7E_7D7C);
    tick();
    check("same_line_no_req", {31'b0, mem_if_en}, 32'h0);

    // Conflict on index 0
    fetch_pc = 32'h0000_0000;
    tick();
    check("conf0_req_pc", mem_if_pc, 32'h0000_0000);
    check("conf0_req_en", {31'b0, mem_if_en}, 32'h1);
    fetch_pc = 32'h0000_0004;
    give_fill(32'h0000_0000);
    check("conf0_inst", fetch_inst, 32'h0706_0504);
    fetch_pc = 32'h0000_0400;
    settle();
    check("conf400_miss", {31'b0, fetch_hit}, 32'h0);
    tick();
    check("conf400_req_pc", mem_if_pc, 32'h0000_0400);
    fetch_pc = 32'h0000_0404;
    give_fill(32'h0000_0400);
    check("conf400_hit", {31'b0, fetch_hit}, 32'h1);
    check("conf400_inst", fetch_inst, 32'h4746_4544);
    fetch_pc = 32'h0000_0000;
    settle();
    check("conf0_evicted", {31'b0, fetch_hit}, 32'h0);
    tick();
    check("conf0_refetch_pc", mem_if_pc, 32'h0000_0000);
    give_fill(32'h0000_0000);

    // Rollback in IDLE suppresses the request
    fetch_pc = 32'h0000_3000;
    rollback = 1'b1;
    tick();
    check("rb_idle_no_req", {31'b0, mem_if_en}, 32'h0);
    rollback = 1'b0;

    // Rollback two cycles into WAIT_MEM does not abort
    fetch_pc = 32'h0000_2080;
    tick();
    check("rb_req_pc", mem_if_pc, 32'h0000_2080);
    tick();
    rollback = 1'b1;
    tick();
    check("rb_wait_en_held", {31'b0, mem_if_en}, 32'h1);
    give_fill(32'h0000_2080);
    rollback = 1'b0;
    settle();
    check("rb_line_hit", {31'b0, fetch_hit}, 32'h1);
    check("rb_line_inst", fetch_inst, 32'h8382_8180);

    // rdy low for 5 cycles while waiting
    fetch_pc = 32'h0000_30C4;
    tick();
    check("stall_req_pc", mem_if_pc, 32'h0000_30C0);
    rdy = 1'b0;
    fetch_pc = 32'h0000_5555;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stall_en", {31'b0, mem_if_en}, 32'h1);
      check("stall_pc", mem_if_pc, 32'h0000_30C0);
    end
    rdy = 1'b1;
    fetch_pc = 32'h0000_30C4;
    give_fill(32'h0000_30C0);
    check("stall_fill_hit", {31'b0, fetch_hit}, 32'h1);
    check("stall_fill_inst", fetch_inst, 32'hC7C6_C5C4);

    // Async reset mid-fill
    fetch_pc = 32'h0000_5100;
    tick();
    check("arst_req_en", {31'b0, mem_if_en}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en_now", {31'b0, mem_if_en}, 32'h0);
    check("arst_pc_now", mem_if_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    fetch_en = 1'b0;
    mem_if_data = build_line(32'h0000_5100);
    mem_if_done = 1'b1;
    tick();
    mem_if_done = 1'b0;
    check("late_done_ignored", {31'b0, mem_if_en}, 32'h0);
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_1044;
    settle();
    check("post_rst_miss", {31'b0, fetch_hit}, 32'h0);
    tick();
    check("post_rst_req_pc", mem_if_pc, 32'h0000_1040);
    check("post_rst_req_en", {31'b0, mem_if_en}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
